// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: drives an active-low reset into a destination-domain synchronizer,
// reads its synchronized reset back, and reports completion (DONE) or timeout (ERR).
module rst_seq_ctrl #(
    parameter int NUM_STAGES     = 2,
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW_RST_REQ,
    input  logic DST_SYNC_RST,
    output logic RST_OUT,
    output logic BUSY,
    output logic DONE,
    output logic ERR
);

    localparam int MAX_CYC = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if (NUM_STAGES < 2) begin : g_bad_stages
        $error("rst_seq_ctrl: NUM_STAGES must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("rst_seq_ctrl: HOLD_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("rst_seq_ctrl: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ASSERT   = 2'd1,
        S_WAIT_LOW = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    logic [NUM_STAGES-1:0] r_sync;
    logic                  w_ack;
    logic                  w_tmo;
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_rst_out;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    // DST_SYNC_RST is asynchronous to CLK; only the last stage is ever observed.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[NUM_STAGES-2:0], DST_SYNC_RST};
        end
    end

    assign w_ack = r_sync[NUM_STAGES-1];
    assign w_tmo = (r_cnt == TMO_LAST);

    // Reset lands in ASSERT so the power-on sequence runs without a request.
    // In the wait states an ack takes priority over a coincident timeout.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= S_ASSERT;
            r_cnt     <= '0;
            r_rst_out <= 1'b0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (SW_RST_REQ) begin
                        r_state   <= S_ASSERT;
                        r_rst_out <= 1'b0;
                        r_cnt     <= '0;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_ASSERT: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= S_WAIT_LOW;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_WAIT_LOW: begin
                    if (!w_ack) begin
                        r_state   <= S_RELEASE;
                        r_rst_out <= 1'b1;
                        r_cnt     <= '0;
                    end else if (w_tmo) begin
                        r_state   <= S_IDLE;
                        r_rst_out <= 1'b1;
                        r_err     <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_RELEASE: begin
                    if (w_ack) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_tmo) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_rst_out <= 1'b1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign RST_OUT = r_rst_out;
    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign ERR     = r_err;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Table-driven bench for rst_seq_ctrl: expected per-edge outputs come from the
// edge timeline of each scenario and are checked through a scoreboard queue.
module tb_rst_seq_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       SW_RST_REQ;
    logic       DST_SYNC_RST;
    logic       RST_OUT;
    logic       BUSY;
    logic       DONE;
    logic       ERR;
    logic [1:0] mode;   // 0: loopback from RST_OUT, 1: tied high, 2: tied low

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string      name;
        int         edge_n;
        logic       rst_out;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    typedef struct {
        string      name;
        logic [1:0] mode;
        bit         por;     // power-on: no request, edges numbered from 1
        int         rise_e;  // first edge after which RST_OUT is high
        int         idle_e;  // edge that returns to IDLE
        bit         err;     // sequence ends in timeout
        bit         spam;    // extra requests while busy
        bit         chain;   // issue a new request in the DONE cycle and stop
        int         rst_at;  // pulse RST after this edge and stop (-1: never)
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];

    rst_seq_ctrl #(
        .NUM_STAGES    (2),
        .HOLD_CYCLES   (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .SW_RST_REQ  (SW_RST_REQ),
        .DST_SYNC_RST(DST_SYNC_RST),
        .RST_OUT     (RST_OUT),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .ERR         (ERR)
    );

    always #5 CLK = ~CLK;

    assign DST_SYNC_RST = (mode == 2'd0) ? RST_OUT : (mode == 2'd1);

    task automatic push_exp(input string name, input int edge_n, input logic ro,
                            input logic b, input logic d, input logic e);
        exp_t x;
        x.name    = name;
        x.edge_n  = edge_n;
        x.rst_out = ro;
        x.busy    = b;
        x.done    = d;
        x.err     = e;
        sb.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: no expected record for sampled outputs");
            return;
        end
        x = sb.pop_front();
        if ({RST_OUT, BUSY, DONE, ERR} !== {x.rst_out, x.busy, x.done, x.err}) begin
            n_bad++;
            $display("FAIL %s edge %0d: RST_OUT,BUSY,DONE,ERR got %b%b%b%b required %b%b%b%b",
                     x.name, x.edge_n, RST_OUT, BUSY, DONE, ERR,
                     x.rst_out, x.busy, x.done, x.err);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int k0;
        mode = v.mode;
        k0   = v.por ? 1 : 0;
        if (!v.por) SW_RST_REQ = 1'b1;
        for (int k = k0; k <= v.idle_e + 3; k++) begin
            push_exp(v.name, k, (k >= v.rise_e), (k < v.idle_e),
                     (k == v.idle_e) && !v.err, v.err && (k >= v.idle_e));
            @(posedge CLK);
            #1;
            SW_RST_REQ = v.spam && (k == 1 || k == 3 || k == 6);
            check_out();
            if (v.chain && k == v.idle_e) begin
                SW_RST_REQ = 1'b1;
                return;
            end
            if (k == v.rst_at) begin
                RST = 1'b0;
                #1;
                push_exp({v.name, "_async"}, k, 1'b0, 1'b1, 1'b0, 1'b0);
                check_out();
                #1;
                RST = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          name         mode  por rise idle err spam chain rst_at
        vecs[0] = '{"por",       2'd0, 1,  5,   8,   0,  0,   0,    -1};
        vecs[1] = '{"req_loop",  2'd0, 0,  5,   8,   0,  0,   0,    -1};
        vecs[2] = '{"wlow_tmo",  2'd1, 0,  20,  20,  1,  0,   0,    -1};
        vecs[3] = '{"rel_tmo",   2'd2, 0,  5,   21,  1,  0,   0,    -1};
        vecs[4] = '{"err_clear", 2'd0, 0,  5,   8,   0,  0,   0,    -1};
        vecs[5] = '{"req_spam",  2'd0, 0,  5,   8,   0,  1,   0,    -1};
        vecs[6] = '{"done_req",  2'd0, 0,  5,   8,   0,  0,   1,    -1};
        vecs[7] = '{"chained",   2'd0, 0,  5,   8,   0,  0,   0,    -1};
        vecs[8] = '{"rst_mid",   2'd0, 0,  5,   8,   0,  0,   0,    6};
        vecs[9] = '{"por_again", 2'd0, 1,  5,   8,   0,  0,   0,    -1};

        RST        = 1'b0;
        SW_RST_REQ = 1'b0;
        mode       = 2'd0;

        for (int i = 0; i < 2; i++) begin
            push_exp("reset_state", 0, 1'b0, 1'b1, 1'b0, 1'b0);
            @(posedge CLK);
            #1;
            check_out();
        end
        RST = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover: %0d records left, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Reset sequencer that drives the asynchronous active-low reset input of a destination-domain reset synchronizer and confirms entry into and exit from reset. It reads the destination's synchronized reset back through its own synchronizer. It performs a power-on reset sequence automatically and also performs a reset sequence on each software/UART-issued request. It reports completion or a timeout to the control FSM in the CLK domain.

## Interface
- NUM_STAGES, 2: flop stages of the DST_SYNC_RST back-synchronizer (>= 2)
- HOLD_CYCLES, 4: minimum cycles RST_OUT held low in ASSERT (>= 1)
- TIMEOUT_CYCLES, 16: max cycles spent in each wait state (>= 2)

- CLK  in  1  sequencer clock
- RST  in  1  reset, asynchronous, active-low
- SW_RST_REQ  in  1  single-cycle reset request, CLK domain
- DST_SYNC_RST  in  1  destination's synchronized reset (active-low), asynchronous to CLK
- RST_OUT  out  1  active-low reset to the destination synchronizer; driven directly from a flop (glitch-free)
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse when a sequence completes successfully
- ERR  out  1  sticky timeout flag

## Operation
- Back-synchronizer: NUM_STAGES-flop chain on DST_SYNC_RST, reset to 0. Its last stage is ack.
- FSM states and transitions:
  - IDLE: if SW_RST_REQ=1, go to ASSERT. On this transition: RST_OUT<=0, cnt<=0, ERR<=0. Otherwise stay.
  - ASSERT: RST_OUT=0. If cnt==HOLD_CYCLES-1, go to WAIT_LOW with cnt<=0. Else cnt++.
  - WAIT_LOW: RST_OUT=0.
    - If ack==0, go to RELEASE with RST_OUT<=1 and cnt<=0.
    - Else if cnt==TIMEOUT_CYCLES-1, go to IDLE with RST_OUT<=1 and ERR<=1.
    - Else cnt++.
  - RELEASE: RST_OUT=1.
    - If ack==1, go to IDLE with DONE<=1.
    - Else if cnt==TIMEOUT_CYCLES-1, go to IDLE with ERR<=1.
    - Else cnt++.
- When the ack condition and the timeout condition occur on the same edge, the ack condition wins (no ERR).
- SW_RST_REQ is ignored outside IDLE. It is not queued.
- DONE is a registered pulse, high exactly one cycle (the first IDLE cycle). A request in that cycle is accepted normally.
- ERR stays set until the next accepted request clears it. Timeout never asserts DONE.
- cnt width is clog2(max(HOLD_CYCLES, TIMEOUT_CYCLES)). cnt saturates implicitly because every path reloads it before overflow.

## Timing
- Reset values (RST=0):
  - state=ASSERT, cnt=0
  - RST_OUT=0, BUSY=1, DONE=0, ERR=0
  - sync chain all 0
- Power-on sequence: it starts on the first CLK edge after RST deasserts, with no request needed.
- RST asserted mid-sequence: all outputs return to their reset values immediately (asynchronous). The sequence restarts from ASSERT on release.
- RST_OUT low duration is at least HOLD_CYCLES+1 cycles: HOLD_CYCLES in ASSERT plus at least one in WAIT_LOW.
- Ack latency is NUM_STAGES edges after DST_SYNC_RST changes.
- Nominal request sequence (HOLD_CYCLES=4, NUM_STAGES=2, DST_SYNC_RST looped from RST_OUT):

  | Edge | Event |
  |---|---|
  | 0 | request sampled; RST_OUT falls |
  | 4 | enter WAIT_LOW |
  | 5 | enter RELEASE; RST_OUT rises |
  | 8 | enter IDLE; DONE high for the cycle after edge 8 |

- Power-on under the same conditions: DONE is high after edge 8, counting the first edge after RST release as edge 1.

## Test plan
- Power-on, loopback DST_SYNC_RST=RST_OUT, default parameters -> RST_OUT low until edge 5; DONE pulses once after edge 8; BUSY falls with it; ERR=0.
- SW_RST_REQ pulse in IDLE at edge 0, loopback -> RST_OUT low edges 0–5; DONE one cycle after edge 8.
- DST_SYNC_RST tied 1, request at edge 0 -> WAIT_LOW entered at edge 4, timeout at edge 20; RST_OUT=1 and ERR=1 after edge 20; no DONE.
- DST_SYNC_RST tied 0, request -> RELEASE entered at edge 5, timeout at edge 21; ERR=1; a new request clears ERR at its acceptance edge.
- SW_RST_REQ repeated during BUSY -> ignored: a single DONE and an unchanged edge timeline. A request in the DONE cycle -> accepted, with RST_OUT falling on that edge.
- RST pulsed low during RELEASE -> RST_OUT=0 and BUSY=1 immediately; the full power-on sequence repeats with DONE after edge 8.
